// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch, load and store-commit requests.
// Build option: define MEM_CTRL_IO_STALL_EN to hold UART-region writes while io_buffer_full is high.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_if_ce,
  input  logic [31:0] in_if_addr,
  output logic        out_if_ce,
  output logic [31:0] out_if_inst,
  input  logic        in_lsb_ce,
  input  logic [5:0]  in_lsb_size,
  input  logic        in_lsb_signed,
  input  logic [31:0] in_lsb_addr,
  output logic        out_lsb_ce,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_ce,
  input  logic [5:0]  in_rob_size,
  input  logic [31:0] in_rob_addr,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_ce,
  input  logic        in_misbranch,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Handshake: every in_*_ce is a single-cycle request pulse with no ready back-pressure;
  // each source owns one pending slot and a pulse hitting an occupied slot is dropped.
  // Every out_*_ce is a single-cycle completion pulse, qualified by rdy like all state.

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;

  logic        if_pend;
  logic [31:0] if_addr_q;
  logic        lsb_pend;
  logic [5:0]  lsb_size_q;
  logic        lsb_signed_q;
  logic [31:0] lsb_addr_q;
  logic        rob_pend;
  logic [5:0]  rob_size_q;
  logic [31:0] rob_addr_q;
  logic [31:0] rob_data_q;

  logic [31:0] act_addr;
  logic [5:0]  act_len;
  logic        act_signed;
  logic [31:0] act_data;
  logic        act_is_if;

  logic [31:0] rd_buf;
  logic [31:0] rd_word;
  logic [31:0] ld_ext;
  logic [1:0]  lane;
  logic [7:0]  wr_byte;
  logic [31:0] cur_addr;
  logic        stall;

  logic        rob_req, lsb_req, if_req;
  logic [31:0] rob_addr_e, rob_data_e, lsb_addr_e, if_addr_e;
  logic [5:0]  rob_size_e, lsb_size_e;
  logic        lsb_signed_e;
  logic        start_rob, start_lsb, start_if;
  logic        finish_rd, finish_wr;

  // A request pulse is visible to the arbiter in its own cycle, so an idle controller
  // starts it without first parking it in the slot.
  assign rob_req      = rob_pend | in_rob_ce;
  assign lsb_req      = (lsb_pend | in_lsb_ce) & ~in_misbranch;
  assign if_req       = (if_pend | in_if_ce) & ~in_misbranch;
  assign rob_addr_e   = rob_pend ? rob_addr_q : in_rob_addr;
  assign rob_data_e   = rob_pend ? rob_data_q : in_rob_data;
  assign rob_size_e   = rob_pend ? rob_size_q : in_rob_size;
  assign lsb_addr_e   = lsb_pend ? lsb_addr_q : in_lsb_addr;
  assign lsb_size_e   = lsb_pend ? lsb_size_q : in_lsb_size;
  assign lsb_signed_e = lsb_pend ? lsb_signed_q : in_lsb_signed;
  assign if_addr_e    = if_pend ? if_addr_q : in_if_addr;

  assign cur_addr  = act_addr + {26'd0, cnt};
  assign dbg_state = state;

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = (state == WRITE) && (cur_addr[17:16] == 2'b11) && io_buffer_full;
`else
  assign stall = io_buffer_full & 1'b0;
`endif

  always_comb begin
    wr_byte = act_data[7:0];
    case (cnt[1:0])
      2'd0: wr_byte = act_data[7:0];
      2'd1: wr_byte = act_data[15:8];
      2'd2: wr_byte = act_data[23:16];
      default: wr_byte = act_data[31:24];
    endcase
  end

  // Byte fetched for address step cnt-1 arrives now; merge it into its lane.
  always_comb begin
    rd_word = rd_buf;
    lane    = cnt[1:0] - 2'd1;
    case (lane)
      2'd0: rd_word[7:0]   = mem_din;
      2'd1: rd_word[15:8]  = mem_din;
      2'd2: rd_word[23:16] = mem_din;
      default: rd_word[31:24] = mem_din;
    endcase
  end

  always_comb begin
    ld_ext = rd_word;
    case (act_len)
      6'd1: ld_ext = {(act_signed ? {24{rd_word[7]}} : 24'd0), rd_word[7:0]};
      6'd2: ld_ext = {(act_signed ? {16{rd_word[15]}} : 16'd0), rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else if (rdy) begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    start_rob = 1'b0;
    start_lsb = 1'b0;
    start_if  = 1'b0;
    finish_rd = 1'b0;
    finish_wr = 1'b0;
    mem_a     = 32'd0;
    mem_wr    = 1'b0;
    mem_dout  = 8'd0;
    case (state)
      IDLE: begin
        if (rob_req) begin
          start_rob = 1'b1;
          state_d   = WRITE;
          cnt_d     = 6'd0;
        end else if (lsb_req) begin
          start_lsb = 1'b1;
          state_d   = READ;
          cnt_d     = 6'd0;
        end else if (if_req) begin
          start_if  = 1'b1;
          state_d   = READ;
          cnt_d     = 6'd0;
        end
      end
      READ: begin
        if (cnt < act_len) mem_a = cur_addr;
        if (in_misbranch) begin
          state_d = IDLE;
        end else if (cnt == act_len) begin
          finish_rd = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      WRITE: begin
        mem_a    = cur_addr;
        mem_dout = wr_byte;
        if (!stall) begin
          mem_wr = 1'b1;
          if (cnt == act_len - 6'd1) begin
            finish_wr = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending slots: consumed on selection, flushed by misbranch for speculative sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pend      <= 1'b0;
      if_addr_q    <= 32'd0;
      lsb_pend     <= 1'b0;
      lsb_size_q   <= 6'd0;
      lsb_signed_q <= 1'b0;
      lsb_addr_q   <= 32'd0;
      rob_pend     <= 1'b0;
      rob_size_q   <= 6'd0;
      rob_addr_q   <= 32'd0;
      rob_data_q   <= 32'd0;
    end else if (rdy) begin
      if (start_rob) begin
        rob_pend <= 1'b0;
      end else if (in_rob_ce && !rob_pend) begin
        rob_pend   <= 1'b1;
        rob_size_q <= in_rob_size;
        rob_addr_q <= in_rob_addr;
        rob_data_q <= in_rob_data;
      end
      if (in_misbranch || start_lsb) begin
        lsb_pend <= 1'b0;
      end else if (in_lsb_ce && !lsb_pend) begin
        lsb_pend     <= 1'b1;
        lsb_size_q   <= in_lsb_size;
        lsb_signed_q <= in_lsb_signed;
        lsb_addr_q   <= in_lsb_addr;
      end
      if (in_misbranch || start_if) begin
        if_pend <= 1'b0;
      end else if (in_if_ce && !if_pend) begin
        if_pend   <= 1'b1;
        if_addr_q <= in_if_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_addr   <= 32'd0;
      act_len    <= 6'd0;
      act_signed <= 1'b0;
      act_data   <= 32'd0;
      act_is_if  <= 1'b0;
      rd_buf     <= 32'd0;
    end else if (rdy) begin
      if (start_rob) begin
        act_addr   <= rob_addr_e;
        act_len    <= rob_size_e;
        act_signed <= 1'b0;
        act_data   <= rob_data_e;
        act_is_if  <= 1'b0;
      end else if (start_lsb) begin
        act_addr   <= lsb_addr_e;
        act_len    <= lsb_size_e;
        act_signed <= lsb_signed_e;
        act_is_if  <= 1'b0;
      end else if (start_if) begin
        act_addr   <= if_addr_e;
        act_len    <= 6'd4;
        act_signed <= 1'b0;
        act_is_if  <= 1'b1;
      end
      if (start_lsb || start_if) begin
        rd_buf <= 32'd0;
      end else if (state == READ && cnt != 6'd0) begin
        rd_buf <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_if_ce    <= 1'b0;
      out_lsb_ce   <= 1'b0;
      out_rob_ce   <= 1'b0;
      out_if_inst  <= 32'd0;
      out_lsb_data <= 32'd0;
    end else if (rdy) begin
      out_if_ce  <= finish_rd & act_is_if;
      out_lsb_ce <= finish_rd & ~act_is_if;
      out_rob_ce <= finish_wr;
      if (finish_rd && act_is_if)  out_if_inst  <= rd_word;
      if (finish_rd && !act_is_if) out_lsb_data <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: table of single-request vectors plus hand-written
// sequences for arbitration, misbranch flush, rdy hold, reset abort and IO stall.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_if_ce, in_lsb_ce, in_lsb_signed, in_rob_ce, in_misbranch, io_buffer_full;
  logic [31:0] in_if_addr, in_lsb_addr, in_rob_addr, in_rob_data;
  logic [5:0]  in_lsb_size, in_rob_size;
  logic        out_if_ce, out_lsb_ce, out_rob_ce, mem_wr;
  logic [31:0] out_if_inst, out_lsb_data, mem_a;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_if_ce(in_if_ce), .in_if_addr(in_if_addr),
    .out_if_ce(out_if_ce), .out_if_inst(out_if_inst),
    .in_lsb_ce(in_lsb_ce), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
    .in_rob_ce(in_rob_ce), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
    .in_rob_data(in_rob_data), .out_rob_ce(out_rob_ce),
    .in_misbranch(in_misbranch), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .dbg_state(dbg_state)
  );

  // Byte RAM: read data appears the cycle after its address.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic load_ram(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[a + 32'(i)] = w[8*i +: 8];
  endtask

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Per-cycle trace, cycle 0 being the cycle the first request pulse is driven.
  logic [63:0] tr_if, tr_lsb, tr_rob, tr_wr, tr_nz;
  logic [31:0] tr_a [64];
  logic [7:0]  tr_dout [64];
  logic [31:0] got_inst, got_data;
  int          cyc;

  task automatic clear_trace();
    tr_if = '0; tr_lsb = '0; tr_rob = '0; tr_wr = '0; tr_nz = '0;
    for (int i = 0; i < 64; i++) begin
      tr_a[i] = '0;
      tr_dout[i] = '0;
    end
    got_inst = '0;
    got_data = '0;
    cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    if (cyc < 64) begin
      tr_if[cyc]   = out_if_ce;
      tr_lsb[cyc]  = out_lsb_ce;
      tr_rob[cyc]  = out_rob_ce;
      tr_wr[cyc]   = mem_wr;
      tr_a[cyc]    = mem_a;
      tr_dout[cyc] = mem_dout;
      tr_nz[cyc]   = ({out_if_ce, out_lsb_ce, out_rob_ce, mem_wr, mem_a, mem_dout,
                       out_if_inst, out_lsb_data} != '0);
    end
    if (out_if_ce)  got_inst = out_if_inst;
    if (out_lsb_ce) got_data = out_lsb_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int first_one(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_inputs();
    in_if_ce = 1'b0; in_lsb_ce = 1'b0; in_rob_ce = 1'b0; in_misbranch = 1'b0;
  endtask

  task automatic pulse_if(input logic [31:0] a);
    in_if_ce = 1'b1; in_if_addr = a;
  endtask

  task automatic pulse_lsb(input int size, input logic sgn, input logic [31:0] a);
    in_lsb_ce = 1'b1; in_lsb_size = 6'(size); in_lsb_signed = sgn; in_lsb_addr = a;
  endtask

  task automatic pulse_rob(input int size, input logic [31:0] a, input logic [31:0] d);
    in_rob_ce = 1'b1; in_rob_size = 6'(size); in_rob_addr = a; in_rob_data = d;
  endtask

  typedef struct {
    int          kind;      // 0 fetch, 1 load, 2 store
    int          size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ram_word;
    logic [31:0] exp_val;
    int          exp_done;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  initial begin
    vec_t        t;
    int          len;
    logic [31:0] mask, w;
    logic [63:0] dv;

    vt[0]  = '{0, 4, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0513, 32'h0000_0513, 6};
    vt[1]  = '{1, 1, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0080, 32'hFFFF_FF80, 3};
    vt[2]  = '{1, 2, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_FF80, 32'h0000_FF80, 4};
    vt[3]  = '{1, 2, 1'b1, 32'h0000_0102, 32'h0, 32'h1234_7FFF, 32'h0000_7FFF, 4};
    vt[4]  = '{1, 1, 1'b0, 32'h0000_0201, 32'h0, 32'h0000_00F0, 32'h0000_00F0, 3};
    vt[5]  = '{1, 4, 1'b1, 32'h0000_0300, 32'h0, 32'h8000_0001, 32'h8000_0001, 6};
    vt[6]  = '{1, 4, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 6};
    vt[7]  = '{1, 2, 1'b1, 32'h0000_0500, 32'h0, 32'h0000_8000, 32'hFFFF_8000, 4};
    vt[8]  = '{2, 4, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 5};
    vt[9]  = '{2, 1, 1'b0, 32'h0003_0000, 32'h0000_0055, 32'h0, 32'h0000_0055, 2};
    vt[10] = '{2, 2, 1'b0, 32'h0000_0401, 32'h1234_ABCD, 32'h0, 32'h0000_ABCD, 3};
    vt[11] = '{2, 4, 1'b0, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0, 32'h0102_0304, 5};

    // Clock/reset
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    in_if_addr = '0; in_lsb_addr = '0; in_rob_addr = '0; in_rob_data = '0;
    in_lsb_size = '0; in_rob_size = '0; in_lsb_signed = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_outputs", 32'({out_if_ce, out_lsb_ce, out_rob_ce, mem_wr, mem_a, mem_dout,
                              out_if_inst, out_lsb_data} != '0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    clear_trace();
    repeat (10) step();
    check("idle_nonzero_cycles", 32'($countones(tr_nz)), 32'd0);
    check("idle_wr_cycles", 32'($countones(tr_wr)), 32'd0);

    // Table-driven single requests
    for (int v = 0; v < NV; v++) begin
      t = vt[v];
      len = t.size;
      if (t.kind != 2) load_ram(t.addr, t.ram_word);
      clear_trace();
      case (t.kind)
        0: pulse_if(t.addr);
        1: pulse_lsb(t.size, t.sgn, t.addr);
        default: pulse_rob(t.size, t.addr, t.data);
      endcase
      step();
      clear_inputs();
      repeat (13) step();
      check($sformatf("v%0d_addr_first", v), tr_a[1], t.addr);
      check($sformatf("v%0d_addr_last", v), tr_a[len], t.addr + 32'(len - 1));
      if (t.kind == 2) begin
        mask = (len == 1) ? 32'hFF : (len == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        w = '0;
        for (int i = 0; i < len; i++) w[8*i +: 8] = rd_ram(t.addr + 32'(i));
        check($sformatf("v%0d_done_cycle", v), 32'(first_one(tr_rob)), 32'(t.exp_done));
        check($sformatf("v%0d_done_count", v), 32'($countones(tr_rob)), 32'd1);
        check($sformatf("v%0d_wr_count", v), 32'($countones(tr_wr)), 32'(len));
        check($sformatf("v%0d_ram", v), w & mask, t.exp_val);
      end else begin
        dv = (t.kind == 0) ? tr_if : tr_lsb;
        check($sformatf("v%0d_done_cycle", v), 32'(first_one(dv)), 32'(t.exp_done));
        check($sformatf("v%0d_done_count", v), 32'($countones(dv)), 32'd1);
        check($sformatf("v%0d_data", v), (t.kind == 0) ? got_inst : got_data, t.exp_val);
      end
    end

    // Same-cycle store, load and fetch: store first, then load, then fetch
    load_ram(32'h600, 32'h1122_3344);
    load_ram(32'h700, 32'hCAFE_F00D);
    clear_trace();
    pulse_rob(4, 32'h200, 32'hDEAD_BEEF);
    pulse_lsb(4, 1'b0, 32'h600);
    pulse_if(32'h700);
    step();
    clear_inputs();
    repeat (21) step();
    check("prio_wr_cycles", 32'(tr_wr[5:0]), 32'b011110);
    check("prio_wr_bytes", {tr_dout[4], tr_dout[3], tr_dout[2], tr_dout[1]}, 32'hDEAD_BEEF);
    check("prio_rob_done", 32'(first_one(tr_rob)), 32'd5);
    check("prio_load_addr", tr_a[6], 32'h600);
    check("prio_load_done", 32'(first_one(tr_lsb)), 32'd11);
    check("prio_load_data", got_data, 32'h1122_3344);
    check("prio_fetch_addr", tr_a[12], 32'h700);
    check("prio_fetch_done", 32'(first_one(tr_if)), 32'd17);
    check("prio_fetch_inst", got_inst, 32'hCAFE_F00D);

    // Second load pulse while the load slot is occupied is ignored
    load_ram(32'h900, 32'h0000_00AA);
    load_ram(32'h904, 32'h0000_00BB);
    clear_trace();
    pulse_rob(1, 32'h980, 32'h0000_0001);
    pulse_lsb(1, 1'b0, 32'h900);
    step();
    clear_inputs();
    pulse_lsb(1, 1'b0, 32'h904);
    step();
    clear_inputs();
    repeat (14) step();
    check("busy_slot_done", 32'(first_one(tr_lsb)), 32'd5);
    check("busy_slot_count", 32'($countones(tr_lsb)), 32'd1);
    check("busy_slot_data", got_data, 32'h0000_00AA);

    // Misbranch during LW: load aborted, pending fetch dropped, pending store runs next
    load_ram(32'h300, 32'h8000_0001);
    clear_trace();
    pulse_lsb(4, 1'b0, 32'h300);
    step();
    clear_inputs();
    pulse_if(32'h10);
    pulse_rob(1, 32'h800, 32'h0000_0077);
    step();
    clear_inputs();
    step();
    in_misbranch = 1'b1;
    step();
    clear_inputs();
    repeat (20) step();
    check("mb_no_load_done", 32'($countones(tr_lsb)), 32'd0);
    check("mb_no_fetch_done", 32'($countones(tr_if)), 32'd0);
    check("mb_abort_wr", 32'(tr_wr[4]), 32'd0);
    check("mb_store_first_wr", 32'(first_one(tr_wr)), 32'd5);
    check("mb_store_addr", tr_a[5], 32'h800);
    check("mb_store_done", 32'(first_one(tr_rob)), 32'd6);

    // Load coincident with misbranch is dropped; coincident store is kept
    clear_trace();
    pulse_lsb(1, 1'b1, 32'h100);
    pulse_rob(1, 32'hA00, 32'h0000_005A);
    in_misbranch = 1'b1;
    step();
    clear_inputs();
    repeat (15) step();
    check("mbc_no_load", 32'($countones(tr_lsb)), 32'd0);
    check("mbc_store_done", 32'(first_one(tr_rob)), 32'd2);
    check("mbc_store_ram", 32'(rd_ram(32'hA00)), 32'h5A);

    // rdy low for three cycles stretches an LB by three cycles
    load_ram(32'h100, 32'h0000_0080);
    clear_trace();
    pulse_lsb(1, 1'b1, 32'h100);
    step();
    clear_inputs();
    rdy = 1'b0;
    repeat (3) step();
    rdy = 1'b1;
    repeat (8) step();
    check("rdy_hold_addr", tr_a[3], 32'h100);
    check("rdy_done_cycle", 32'(first_one(tr_lsb)), 32'd6);
    check("rdy_done_count", 32'($countones(tr_lsb)), 32'd1);
    check("rdy_data", got_data, 32'hFFFF_FF80);

    // Reset in the middle of an LW: no completion, controller idle afterwards
    clear_trace();
    pulse_lsb(4, 1'b0, 32'h300);
    step();
    clear_inputs();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    check("rst_mid_no_done", 32'($countones(tr_lsb)), 32'd0);
    check("rst_mid_idle_addr", tr_a[5], 32'h0);

    // UART-region byte store with io_buffer_full high for five cycles
    clear_trace();
    pulse_rob(1, 32'h0003_0000, 32'h0000_003C);
    step();
    clear_inputs();
    io_buffer_full = 1'b1;
    repeat (5) step();
    io_buffer_full = 1'b0;
    repeat (8) step();
    check("io_wr_count", 32'($countones(tr_wr)), 32'd1);
    check("io_store_ram", 32'(rd_ram(32'h0003_0000)), 32'h3C);
`ifdef MEM_CTRL_IO_STALL_EN
    check("io_first_wr", 32'(first_one(tr_wr)), 32'd6);
    check("io_done", 32'(first_one(tr_rob)), 32'd7);
`else
    check("io_first_wr", 32'(first_one(tr_wr)), 32'd1);
    check("io_done", 32'(first_one(tr_rob)), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on posedge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global enable; when low, all state and outputs hold.
REQ-004 in_if_ce / in_if_addr  in  1/32  instruction fetch request pulse and word address.
REQ-005 out_if_ce / out_if_inst  out  1/32  fetch done pulse and little-endian word.
REQ-006 in_lsb_ce / in_lsb_size / in_lsb_signed / in_lsb_addr  in  1/6/1/32  load request pulse, byte count, sign flag, address.
REQ-007 out_lsb_ce / out_lsb_data  out  1/32  load done pulse and extended data.
REQ-008 in_rob_ce / in_rob_size / in_rob_addr / in_rob_data  in  1/6/32/32  store-commit request pulse, byte count, address, data.
REQ-009 out_rob_ce  out  1  store done pulse.
REQ-010 in_misbranch  in  1  flush of speculative reads.
REQ-011 mem_din  in  8  RAM read byte.
REQ-012 mem_dout / mem_a / mem_wr  out  8/32/1  RAM write byte, byte address, write strobe (1 = write).
REQ-013 io_buffer_full  in  1  UART transmit buffer full.

Function
REQ-014 Requests are one-cycle pulses; each source SHALL be latched in a per-source pending slot, at most one per source; a pulse arriving while that slot is occupied is a requester error and SHALL be ignored.
REQ-015 States IDLE, READ, WRITE; in IDLE, when rdy is high, highest-priority pending slot is selected: store > load > fetch; selection cycle drives mem_wr=0, mem_a=0.
REQ-016 Size values 1, 2, 4 only; fetch always 4 bytes.
REQ-017 READ: mem_a = addr+k in k-th cycle after selection (k=0..N-1); mem_din is valid the cycle after its address and is captured into byte lane k.
REQ-018 Read latency, request pulse in cycle 0 with controller idle and no higher-priority work: mem_a=addr in cycle 1, done pulse in cycle N+2 (LW/fetch: cycle 6).
REQ-019 WRITE: mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] in cycles 1..N; out_rob_ce pulses in cycle N+1 (SW: cycle 5).
REQ-020 Done pulses last exactly one cycle; the controller re-enters IDLE in the done cycle, so the next selected request drives its first address one cycle later.
REQ-021 Load extension: signed LB sign-extends bit 7, signed LH bit 15; unsigned zero-extends; size 4 ignores signed.
REQ-022 Address arithmetic is 32-bit modulo 2^32; no alignment check.
REQ-023 in_misbranch high (rdy high): clear pending load and fetch slots, abort an in-progress READ (IDLE next cycle, no done pulse, mem_wr=0); in-progress WRITE and pending store are unaffected.
REQ-024 A request pulse coincident with in_misbranch for the same (load/fetch) source is dropped; a coincident store pulse is latched.
REQ-025 When not writing, mem_wr SHALL be 0; mem_dout value is don't-care.

Reset
REQ-026 On rst: state IDLE, all pending slots empty, out_if_ce=out_lsb_ce=out_rob_ce=0, mem_wr=0, mem_a=0, mem_dout=0, out_if_inst=out_lsb_data=0.
REQ-027 rst mid-transfer aborts it with no done pulse; rst has priority over rdy.

Configuration
REQ-028 Macro MEM_CTRL_IO_STALL_EN defined: a WRITE byte whose address has addr[17:16]==2'b11 while io_buffer_full=1 is held (mem_wr=0, k unchanged) until io_buffer_full=0, delaying done accordingly.
REQ-029 Macro undefined: io_buffer_full is ignored; port remains present.

Verification
REQ-030 Reset then idle: all outputs 0 for 10 cycles, mem_wr never 1.
REQ-031 Fetch 0x0000_0010, RAM bytes 13 05 00 00: mem_a 0x10..0x13 cycles 1-4, out_if_ce cycle 6, out_if_inst=0x00000513.
REQ-032 LB signed addr 0x100, RAM 0x80 -> out_lsb_data=0xFFFFFF80 cycle 3; LHU addr 0x100, bytes 80 FF -> 0x0000FF80.
REQ-033 Same-cycle store SW 0x200 data 0xDEADBEEF, load, fetch -> write bytes EF BE AD DE first, out_rob_ce cycle 5, then load, then fetch.
REQ-034 LW in progress, in_misbranch in cycle 3 -> no out_lsb_ce, pending fetch dropped, pending store executes next.
REQ-035 With MEM_CTRL_IO_STALL_EN: SB to 0x30000 with io_buffer_full high 5 cycles -> mem_wr stays 0 then 1 once, out_rob_ce 5 cycles later than unstalled; without macro no stall.
